window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Streaming 3x3 neighbourhood generator that feeds the nine-input bitwise median stage. It accepts a raster-order pixel stream, one pixel per accepted beat, and buffers the two previous image lines. For every pixel whose full 3x3 neighbourhood lies inside the frame, it presents the nine neighbourhood pixels in parallel, with a valid strobe. No border padding is applied; edge pixels produce no window.

## Interface

- WIDTH, 16, pixel width in bits
- IMG_W, 64, pixels per line; legal range 3..4096
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_pix is accepted this cycle; no backpressure, every asserted beat is consumed
- in_sof  input  1  start of frame; qualified by in_valid; marks the first pixel of a frame
- in_pix  input  WIDTH  pixel, raster order
- out_valid  output  1  a..k hold a complete window this cycle (one-cycle strobe)
- a, b, c  output  WIDTH each  top row of the window, left to right: (r-2,c-2), (r-2,c-1), (r-2,c)
- d, e, f  output  WIDTH each  middle row of the window: (r-1,c-2), (r-1,c-1), (r-1,c)
- g, h, k  output  WIDTH each  bottom row of the window: (r,c-2), (r,c-1), (r,c); k is the newest pixel

## Operation

- Counters:
  - col counts 0..IMG_W-1 and wraps to 0.
  - row is a 2-bit counter that saturates at 2 and increments on each col wrap.
- Line buffers:
  - lb0 holds line r-1 and lb1 holds line r-2, each IMG_W x WIDTH and indexed by col.
  - Implementation may use RAM or shift registers; read-before-write semantics are required.
- On each accepted beat at column col, all of the following happen:
  - Window registers shift left by one column.
  - The new right column is {lb1[col], lb0[col], in_pix}, loaded into c, f, k.
  - lb1[col] <= lb0[col] and lb0[col] <= in_pix.
  - col and row advance.
- Window validity: out_valid is asserted the cycle after an accepted beat that had row==2 and col>=2, where row and col are the values before they advance.
- in_sof with in_valid:
  - The pixel is treated as col=0, row=0, regardless of the current counters.
  - Any window in progress is abandoned.
  - Line buffer contents are not cleared; they are don't-care because gating depends only on row.
- in_sof without in_valid is ignored.
- Valid windows per frame of H lines: (IMG_W-2)*(H-2). Frame height is not a parameter; the next in_sof resynchronizes.
- Idle cycles (in_valid=0):
  - No state changes.
  - out_valid=0.
  - a..k keep their last values.
- Reset behaviour:
  - col=0, row=0, out_valid=0, a..k all zero.
  - Line buffers are not reset.

## Timing

- Latency: 1 cycle from an accepted in_pix to out_valid/k carrying it.
- Throughput: one window per clock when in_valid is held high.
- Bubbles in in_valid are permitted anywhere, including mid-line; they stretch timing but do not alter window contents.
- rst has priority over in_valid/in_sof in the same cycle. A pixel presented during rst is dropped.
- When rst is asserted mid-frame, the stream must restart with in_sof. Without in_sof, counting resumes from col=0 and row=0.
- in_sof on a beat that would otherwise wrap col: in_sof wins, and that pixel is at column 0.
- Row/col counter arithmetic is modulo IMG_W for col. The col counter width is clog2(IMG_W).

## Test plan

- IMG_W=4, rst then a ramp 0..15 with in_sof on pixel 0 and in_valid held high:
  - The first out_valid comes one cycle after pixel 10 is accepted, with a..k = 0,1,2,4,5,6,8,9,10.
  - Exactly 4 strobes occur in total, on pixels 10, 11, 14 and 15.
- Same ramp, checking the column wrap:
  - Pixels 12 and 13 give no out_valid.
  - Pixel 14 gives a..k = 4,5,6,8,9,10,12,13,14.
- Same ramp with in_valid deasserted for 3 cycles after every pixel:
  - The same 4 windows with identical values are produced.
  - out_valid is never asserted during a bubble, and a..k hold their values during bubbles.
- in_sof reasserted on pixel 13 (value 13) followed by ramp 14..:
  - No out_valid until pixel index 10 of the new frame.
  - The new frame's first window is drawn from the post-sof pixels only.
- rst pulsed for 1 cycle during pixel 11:
  - The next cycle shows out_valid=0 and a..k=0.
  - Pixel 11 is dropped.
  - A restarted ramp with in_sof behaves exactly as in the first scenario.
- IMG_W=3, constant input 16'hFFFF for 3 lines: exactly one window, with all of a..k = 16'hFFFF.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 window
// register bank, emitting one window per accepted pixel once the
// neighbourhood lies fully inside the frame.
module window_3x3_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMG_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_pix,
  output logic             out_valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] k
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = 2;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Line r-1 (lb0) and line r-2 (lb1); contents are never reset
  logic [WIDTH-1:0] lb0 [IMG_W];
  logic [WIDTH-1:0] lb1 [IMG_W];

  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_next;
  logic             win_ok;
  logic [WIDTH-1:0] lb0_rd;
  logic [WIDTH-1:0] lb1_rd;

  // Position of the current beat (sof forces column 0 of row 0) and counter advance
  always_comb begin
    eff_col  = col;
    eff_row  = row;
    col_next = col;
    row_next = row;
    if (in_sof) begin
      eff_col = '0;
      eff_row = '0;
    end
    lb0_rd = lb0[eff_col];
    lb1_rd = lb1[eff_col];
    if (eff_col == COL_W'(IMG_W - 1)) begin
      col_next = '0;
      row_next = (eff_row == ROW_W'(2)) ? eff_row : eff_row + ROW_W'(1);
    end else begin
      col_next = eff_col + COL_W'(1);
      row_next = eff_row;
    end
    win_ok = (eff_row == ROW_W'(2)) && (eff_col >= COL_W'(2));
  end

  // Counters, window shift and valid strobe; idle beats hold everything but the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      a <= '0; b <= '0; c <= '0;
      d <= '0; e <= '0; f <= '0;
      g <= '0; h <= '0; k <= '0;
    end else if (in_valid) begin
      col       <= col_next;
      row       <= row_next;
      out_valid <= win_ok;
      a <= b; b <= c; c <= lb1_rd;
      d <= e; e <= f; f <= lb0_rd;
      g <= h; h <= k; k <= in_pix;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Line buffer update: read-before-write via non-blocking assignment; dropped while in reset
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb1[eff_col] <= lb0_rd;
      lb0[eff_col] <= in_pix;
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen: ramps on a 4-wide image and a constant
// frame on a 3-wide image, with expected windows computed from pixel positions.
module tb_window_3x3_gen;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned W4    = 4;
  localparam int unsigned W3    = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_sof;
  logic [WIDTH-1:0] in_pix;
  logic out_valid;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h, k;

  logic in_valid3, in_sof3;
  logic [WIDTH-1:0] in_pix3;
  logic out_valid3;
  logic [WIDTH-1:0] a3, b3, c3, d3, e3, f3, g3, h3, k3;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  window_3x3_gen #(.WIDTH(WIDTH), .IMG_W(W4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(out_valid), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .k(k)
  );

  window_3x3_gen #(.WIDTH(WIDTH), .IMG_W(W3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_sof(in_sof3), .in_pix(in_pix3),
    .out_valid(out_valid3), .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3), .g(g3), .h(h3), .k(k3)
  );

  function automatic logic [9*WIDTH-1:0] win4();
    return {a, b, c, d, e, f, g, h, k};
  endfunction

  function automatic logic [9*WIDTH-1:0] win3();
    return {a3, b3, c3, d3, e3, f3, g3, h3, k3};
  endfunction

  // Window of frame pixel idx on a w-wide image whose pixel (r,c) has value off + r*w + c
  function automatic logic [9*WIDTH-1:0] exp_win(int idx, int off, int w);
    logic [9*WIDTH-1:0] res = '0;
    int r = idx / w;
    int cl = idx % w;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        res = (res << WIDTH) | (9*WIDTH)'(WIDTH'(off + (r - 2 + rr) * w + (cl - 2 + cc)));
    return res;
  endfunction

  function automatic logic exp_valid(int idx, int w);
    return ((idx / w) >= 2) && ((idx % w) >= 2);
  endfunction

  task automatic chk(input string tag, input logic [9*WIDTH-1:0] obs, input logic [9*WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present one beat on the 4-wide DUT; returns at the next falling edge
  task automatic beat(input logic v, input logic s, input logic [WIDTH-1:0] p);
    in_valid = v;
    in_sof   = s;
    in_pix   = p;
    @(negedge clk);
    if (out_valid === 1'b1) strobes++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_pix = '0;
    in_valid3 = 1'b0; in_sof3 = 1'b0; in_pix3 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", (9*WIDTH)'(out_valid), '0);
    chk("reset_win", win4(), '0);
  endtask

  // n pixels valued off+j at frame index first+j, sof on the first, gap idle cycles after each
  task automatic run_ramp(input string tag, input int off, input int n, input int first, input int gap);
    logic [9*WIDTH-1:0] held;
    logic have;
    for (int j = 0; j < n; j++) begin
      beat(1'b1, j == 0, WIDTH'(off + j));
      have = exp_valid(first + j, W4);
      chk($sformatf("%s_valid_%0d", tag, first + j), (9*WIDTH)'(out_valid), (9*WIDTH)'(have));
      held = exp_win(first + j, off - first, W4);
      if (have) chk($sformatf("%s_win_%0d", tag, first + j), win4(), held);
      for (int i = 0; i < gap; i++) begin
        beat(1'b0, 1'b0, 16'hDEAD);
        chk($sformatf("%s_bubble_valid_%0d", tag, first + j), (9*WIDTH)'(out_valid), '0);
        if (have) chk($sformatf("%s_bubble_hold_%0d", tag, first + j), win4(), held);
      end
    end
    beat(1'b0, 1'b0, '0);
    chk($sformatf("%s_idle_valid", tag), (9*WIDTH)'(out_valid), '0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_pix = '0;
    in_valid3 = 1'b0; in_sof3 = 1'b0; in_pix3 = '0;
    @(negedge clk);

    // Continuous ramp: windows on pixels 10, 11, 14, 15 only
    do_reset();
    strobes = 0;
    run_ramp("ramp", 0, 16, 0, 0);
    chk("ramp_strobes", (9*WIDTH)'(strobes), (9*WIDTH)'(4));
    chk("ramp_last_hold", win4(), exp_win(15, 0, W4));

    // Same ramp with 3 bubble cycles after each pixel
    do_reset();
    strobes = 0;
    run_ramp("bubble", 0, 16, 0, 3);
    chk("bubble_strobes", (9*WIDTH)'(strobes), (9*WIDTH)'(4));

    // sof re-asserted on pixel 13 restarts the frame
    do_reset();
    strobes = 0;
    run_ramp("pre_sof", 0, 13, 0, 0);
    run_ramp("post_sof", 13, 16, 0, 0);
    chk("sof_strobes", (9*WIDTH)'(strobes), (9*WIDTH)'(6));

    // Reset pulsed while pixel 11 is presented, then a fresh ramp
    do_reset();
    for (int j = 0; j < 11; j++) beat(1'b1, j == 0, WIDTH'(j));
    chk("pre_rst_win", win4(), exp_win(10, 0, W4));
    rst = 1'b1;
    beat(1'b1, 1'b0, WIDTH'(11));
    rst = 1'b0;
    chk("rst_mid_valid", (9*WIDTH)'(out_valid), '0);
    chk("rst_mid_win", win4(), '0);
    strobes = 0;
    run_ramp("restart", 0, 16, 0, 0);
    chk("restart_strobes", (9*WIDTH)'(strobes), (9*WIDTH)'(4));

    // 3-wide image, three constant lines: exactly one all-ones window
    do_reset();
    begin
      int s3 = 0;
      for (int j = 0; j < 9; j++) begin
        in_valid3 = 1'b1;
        in_sof3   = (j == 0);
        in_pix3   = 16'hFFFF;
        @(negedge clk);
        if (out_valid3 === 1'b1) s3++;
        chk($sformatf("w3_valid_%0d", j), (9*WIDTH)'(out_valid3), (9*WIDTH)'(j == 8));
      end
      chk("w3_win", win3(), {9{16'hFFFF}});
      in_valid3 = 1'b0;
      in_sof3   = 1'b0;
      @(negedge clk);
      chk("w3_idle_valid", (9*WIDTH)'(out_valid3), '0);
      chk("w3_strobes", (9*WIDTH)'(s3), (9*WIDTH)'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
